servant_sleep_ctrl: RTL and testbench

Multi-domain clock-enable and sleep/wakeup controller for servant-class SoCs. It generalises the board-level single gated clock into DOMAINS independently gated clock domains. Each domain has a per-domain FSM with reset stretching, a drain window, a wake-source mask and a programmable settle delay. It sits between the board clock generator and the servant instances, and drives clock-enable and reset for each domain.

---
 rtl/servant_sleep_ctrl.sv | 143 ++++++++++++++
 tb/tb_servant_sleep_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_sleep_ctrl.sv
// Multi-domain clock-enable and sleep/wake controller.
// Each domain runs its own RST_HOLD/RUN/DRAIN/SLEEP/WAKE sequencer.
module servant_sleep_ctrl #(
    parameter int DOMAINS      = 2,
    parameter int WAKE_SRCS    = 4,
    parameter int RST_CYCLES   = 16,
    parameter int DRAIN_CYCLES = 2,
    parameter int SETTLE_W     = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [DOMAINS-1:0]             i_sleep_req,
    input  logic [WAKE_SRCS-1:0]           i_wake_src,
    input  logic [DOMAINS*WAKE_SRCS-1:0]   i_wake_mask,
    input  logic [SETTLE_W-1:0]            i_settle,
    output logic [DOMAINS-1:0]             o_clk_en,
    output logic [DOMAINS-1:0]             o_rst,
    output logic [DOMAINS-1:0]             o_wakeup_req,
    output logic [DOMAINS-1:0]             o_asleep
);

    localparam int MAX_RD = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int MAX_C  = (MAX_RD > (1 << SETTLE_W)) ? MAX_RD : (1 << SETTLE_W);
    localparam int CW     = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {
        RST_HOLD,
        RUN,
        DRAIN,
        SLEEP,
        WAKE
    } state_t;

    state_t          state_q [DOMAINS];
    state_t          state_d [DOMAINS];
    logic [CW-1:0]   cnt_q   [DOMAINS];
    logic [CW-1:0]   cnt_d   [DOMAINS];

    logic [DOMAINS-1:0] clk_en_q, clk_en_d;
    logic [DOMAINS-1:0] rst_q, rst_d;
    logic [DOMAINS-1:0] wakeup_q, wakeup_d;
    logic [DOMAINS-1:0] asleep_q, asleep_d;
    logic [DOMAINS-1:0] wake;
    logic [CW-1:0]      settle_eff;

    // A programmed settle of zero still costs one WAKE cycle.
    always_comb begin
        settle_eff = CW'(i_settle);
        if (i_settle == '0) begin
            settle_eff = CW'(1);
        end
    end

    always_comb begin
        for (int d = 0; d < DOMAINS; d++) begin
            wake[d] = |(i_wake_src & i_wake_mask[d*WAKE_SRCS +: WAKE_SRCS]);
        end
    end

    always_comb begin
        for (int d = 0; d < DOMAINS; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            unique case (state_q[d])
                RST_HOLD: begin
                    if (cnt_q[d] == CW'(RST_CYCLES - 1)) begin
                        state_d[d] = RUN;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CW'(1);
                    end
                end
                RUN: begin
                    if (i_sleep_req[d]) begin
                        state_d[d] = DRAIN;
                        cnt_d[d]   = '0;
                    end
                end
                DRAIN: begin
                    if (wake[d]) begin
                        state_d[d] = RUN;
                    end else if (cnt_q[d] >= CW'(DRAIN_CYCLES)) begin
                        state_d[d] = SLEEP;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CW'(1);
                    end
                end
                SLEEP: begin
                    if (wake[d]) begin
                        state_d[d] = WAKE;
                        cnt_d[d]   = '0;
                    end
                end
                WAKE: begin
                    if (cnt_q[d] >= settle_eff) begin
                        state_d[d] = RUN;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CW'(1);
                    end
                end
                default: begin
                    state_d[d] = RST_HOLD;
                    cnt_d[d]   = '0;
                end
            endcase

            // Outputs are registered from the next state.
            asleep_d[d] = (state_d[d] == SLEEP) || (state_d[d] == WAKE);
            clk_en_d[d] = !asleep_d[d];
            rst_d[d]    = (state_d[d] == RST_HOLD);
            wakeup_d[d] = (state_d[d] == RUN) &&
                          ((state_q[d] == WAKE) || (state_q[d] == DRAIN));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int d = 0; d < DOMAINS; d++) begin
                state_q[d] <= RST_HOLD;
                cnt_q[d]   <= '0;
            end
            clk_en_q <= '1;
            rst_q    <= '1;
            wakeup_q <= '0;
            asleep_q <= '0;
        end else begin
            for (int d = 0; d < DOMAINS; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
            clk_en_q <= clk_en_d;
            rst_q    <= rst_d;
            wakeup_q <= wakeup_d;
            asleep_q <= asleep_d;
        end
    end

    assign o_clk_en     = clk_en_q;
    assign o_rst        = rst_q;
    assign o_wakeup_req = wakeup_q;
    assign o_asleep     = asleep_q;

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// Bench for servant_sleep_ctrl: vector table, directed corner cases
// and randomized traffic against an event-countdown reference model.
module tb_servant_sleep_ctrl;

    localparam int D  = 2;
    localparam int W  = 4;
    localparam int RC = 16;
    localparam int DC = 2;
    localparam int SW = 8;

    logic              clk;
    logic              rst;
    logic [D-1:0]      sleep_req;
    logic [W-1:0]      wake_src;
    logic [D*W-1:0]    wake_mask;
    logic [SW-1:0]     settle;
    logic [D-1:0]      clk_en;
    logic [D-1:0]      drst;
    logic [D-1:0]      wakeup;
    logic [D-1:0]      asleep;

    int vectors;
    int miscompares;

    servant_sleep_ctrl #(
        .DOMAINS(D), .WAKE_SRCS(W), .RST_CYCLES(RC),
        .DRAIN_CYCLES(DC), .SETTLE_W(SW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sleep_req(sleep_req),
        .i_wake_src(wake_src),
        .i_wake_mask(wake_mask),
        .i_settle(settle),
        .o_clk_en(clk_en),
        .o_rst(drst),
        .o_wakeup_req(wakeup),
        .o_asleep(asleep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges since release, plus per-domain countdowns.
    int m_edges;
    bit m_drain [D];
    bit m_sleep [D];
    bit m_waking [D];
    bit m_pulse [D];
    int m_drain_rem [D];
    int m_wake_el [D];

    function automatic void model_reset();
        m_edges = 0;
        for (int d = 0; d < D; d++) begin
            m_drain[d] = 0; m_sleep[d] = 0; m_waking[d] = 0;
            m_pulse[d] = 0; m_drain_rem[d] = 0; m_wake_el[d] = 0;
        end
    endfunction

    function automatic void model_edge();
        int need;
        bit w;
        need = (settle == 0) ? 1 : int'(settle);
        for (int d = 0; d < D; d++) begin
            logic [W-1:0] m;
            m = wake_mask[d*W +: W];
            w = |(wake_src & m);
            m_pulse[d] = 0;
            if (m_edges < RC) begin
            end else if (m_drain[d]) begin
                if (w) begin
                    m_drain[d] = 0; m_pulse[d] = 1;
                end else begin
                    m_drain_rem[d]--;
                    if (m_drain_rem[d] == 0) begin
                        m_drain[d] = 0; m_sleep[d] = 1;
                    end
                end
            end else if (m_sleep[d]) begin
                if (w) begin
                    m_sleep[d] = 0; m_waking[d] = 1; m_wake_el[d] = 0;
                end
            end else if (m_waking[d]) begin
                m_wake_el[d]++;
                if (m_wake_el[d] > need) begin
                    m_waking[d] = 0; m_pulse[d] = 1;
                end
            end else if (sleep_req[d]) begin
                m_drain[d] = 1; m_drain_rem[d] = DC + 1;
            end
        end
        if (m_edges < RC) m_edges++;
    endfunction

    task automatic cmp(input string nm, input logic [D-1:0] ec,
                       input logic [D-1:0] er, input logic [D-1:0] ew,
                       input logic [D-1:0] ea);
        vectors++;
        if ({clk_en, drst, wakeup, asleep} !== {ec, er, ew, ea}) begin
            miscompares++;
            $display("FAIL %s t=%0t clk_en=%b exp %b rst=%b exp %b wk=%b exp %b asleep=%b exp %b",
                     nm, $time, clk_en, ec, drst, er, wakeup, ew, asleep, ea);
        end
    endtask

    task automatic check_model(input string nm);
        logic [D-1:0] ec, er, ew, ea;
        for (int d = 0; d < D; d++) begin
            ea[d] = m_sleep[d] | m_waking[d];
            ec[d] = ~ea[d];
            er[d] = (m_edges < RC);
            ew[d] = m_pulse[d];
        end
        cmp(nm, ec, er, ew, ea);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [D-1:0]   req;
        logic [W-1:0]   src;
        logic [D*W-1:0] mask;
        logic [SW-1:0]  settle;
        logic [D-1:0]   ec;
        logic [D-1:0]   ea;
        logic [D-1:0]   ew;
    } vec_t;

    vec_t tbl [21];

    initial begin
        vectors = 0;
        miscompares = 0;
        tbl[0]  = '{2'b01, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[1]  = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[2]  = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[3]  = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b10, 2'b01, 2'b00};
        tbl[4]  = '{2'b01, 4'b0000, 8'h21, 8'd2, 2'b10, 2'b01, 2'b00};
        tbl[5]  = '{2'b00, 4'b0001, 8'h21, 8'd2, 2'b10, 2'b01, 2'b00};
        tbl[6]  = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b10, 2'b01, 2'b00};
        tbl[7]  = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b10, 2'b01, 2'b00};
        tbl[8]  = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b01};
        tbl[9]  = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[10] = '{2'b10, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[11] = '{2'b00, 4'b0010, 8'h21, 8'd2, 2'b11, 2'b00, 2'b10};
        tbl[12] = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[13] = '{2'b11, 4'b0010, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[14] = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[15] = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b11, 2'b00, 2'b00};
        tbl[16] = '{2'b00, 4'b0000, 8'h21, 8'd2, 2'b00, 2'b11, 2'b00};
        tbl[17] = '{2'b00, 4'b0011, 8'h21, 8'd0, 2'b00, 2'b11, 2'b00};
        tbl[18] = '{2'b00, 4'b0000, 8'h21, 8'd0, 2'b00, 2'b11, 2'b00};
        tbl[19] = '{2'b00, 4'b0000, 8'h21, 8'd0, 2'b11, 2'b00, 2'b11};
        tbl[20] = '{2'b00, 4'b0000, 8'h21, 8'd0, 2'b11, 2'b00, 2'b00};

        rst = 1'b1;
        sleep_req = '0; wake_src = '0; wake_mask = '0; settle = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_values", 2'b11, 2'b11, 2'b00, 2'b00);
        #3 rst = 1'b0;

        // Reset stretch after release.
        for (int i = 1; i <= RC; i++) begin
            step();
            check_model("rst_hold");
            if (i == RC - 1) cmp("rst_last_high", 2'b11, 2'b11, 2'b00, 2'b00);
            if (i == RC)     cmp("rst_released", 2'b11, 2'b00, 2'b00, 2'b00);
        end

        // Vector table.
        for (int i = 0; i < 21; i++) begin
            sleep_req = tbl[i].req;
            wake_src  = tbl[i].src;
            wake_mask = tbl[i].mask;
            settle    = tbl[i].settle;
            step();
            cmp($sformatf("tbl[%0d]", i), tbl[i].ec, 2'b00, tbl[i].ew, tbl[i].ea);
            check_model($sformatf("tbl_model[%0d]", i));
        end
        sleep_req = '0; wake_src = '0;

        // Source masked out of domain0 but into domain1.
        settle = 8'd3;
        wake_mask = 8'b0100_0000;
        sleep_req = 2'b11;
        step(); check_model("mask_req");
        sleep_req = '0;
        repeat (3) begin step(); check_model("mask_drain"); end
        cmp("mask_both_asleep", 2'b00, 2'b00, 2'b00, 2'b11);
        wake_src = 4'b0100;
        repeat (40) begin step(); check_model("mask_hold"); end
        cmp("mask_d0_stays", 2'b10, 2'b00, 2'b00, 2'b01);
        wake_src = '0;

        // Async reset while domain0 is in a long WAKE.
        settle = 8'd200;
        wake_mask = 8'b0000_0001;
        wake_src = 4'b0001;
        step(); check_model("wake_enter");
        wake_src = '0;
        repeat (10) begin step(); check_model("wake_long"); end
        cmp("wake_still_asleep", 2'b10, 2'b00, 2'b00, 2'b01);
        #2 rst = 1'b1;
        #1;
        cmp("async_reset", 2'b11, 2'b11, 2'b00, 2'b00);
        model_reset();
        #3 rst = 1'b0;
        for (int i = 1; i <= RC; i++) begin
            step();
            check_model("rst_hold2");
            if (i == RC - 1) cmp("rst2_last_high", 2'b11, 2'b11, 2'b00, 2'b00);
            if (i == RC)     cmp("rst2_released", 2'b11, 2'b00, 2'b00, 2'b00);
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) wake_mask = D*W'($urandom);
            if ($urandom_range(0, 19) == 0) settle = SW'($urandom_range(0, 6));
            for (int d = 0; d < D; d++) begin
                sleep_req[d] = ($urandom_range(0, 7) == 0);
            end
            for (int s = 0; s < W; s++) begin
                if ($urandom_range(0, 15) == 0) wake_src[s] = ~wake_src[s];
            end
            step();
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
